// File: rtl/line_bus_pkg.sv
// line_bus_pkg: shared constants, FSM state type and helpers for the 16-bit cache-line burst bus.
package line_bus_pkg;
   localparam int LINE_HWORDS = 128;
   localparam int HWORD_W = 16;
   localparam int LINE_ADDR_W = 24;
   localparam int IDX_W = $clog2(LINE_HWORDS);
   typedef enum logic [2:0] {IDLE, LAT, BURST, FLUSH, HOLD} lmr_state_t;
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/lmr_store.sv
// lmr_store: simple dual-port block RAM with registered, enable-held read data.
module lmr_store #(
   parameter int AW = 13,
   parameter int DW = 16
) (
   input  logic          cpu_clk,
   input  logic          rst,
   input  logic          re,
   input  logic [AW-1:0] ra,
   output logic [DW-1:0] rdata,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd
);
   logic [DW-1:0] mem_q [1<<AW];
   logic [DW-1:0] rd_q;
   // contents are deliberately not reset; only the read register is
   always_ff @(posedge cpu_clk) begin
      if (we) mem_q[wa] <= wd;
   end
   always_ff @(posedge cpu_clk) begin
      if (rst) rd_q <= '0;
      else if (re) rd_q <= mem_q[ra];
   end
   assign rdata = rd_q;
endmodule

// File: rtl/line_mem_responder.sv
// line_mem_responder: SDRAM-like line burst responder backed by block RAM.
// Optional LINE_MEM_RESP_STATS_EN adds saturating burst/alias counters on stat_* outputs.
module line_mem_responder
   import line_bus_pkg::*;
#(
   parameter int LINE_BITS = 6,
   parameter int START_LAT = 4,
   parameter int GAP = 0,
   parameter int PUT_LAT = 2
) (
   input  logic                   cpu_clk,
   input  logic                   rst,
   input  logic [LINE_ADDR_W-1:0] ram_addr,
   input  logic                   ram_rd,
   input  logic                   ram_wr,
   input  logic [HWORD_W-1:0]     ram_din,
   output logic [HWORD_W-1:0]     ram_dout,
   output logic                   ram_get,
   output logic                   ram_put,
   output logic                   busy,
   output logic                   addr_err,
   output logic [15:0]            stat_rd,
   output logic [15:0]            stat_wr,
   output logic [15:0]            stat_alias
);
   lmr_state_t state_q;
   logic [LINE_BITS-1:0] line_q;
   logic wr_q, get_q, put_q, busy_q, err_q;
   logic [IDX_W-1:0] idx_q;
   logic [7:0] cnt_q;
   logic [PUT_LAT-1:0] pv_q;
   logic [IDX_W-1:0] pi_q [PUT_LAT];
   logic req, last, fire, out_of_range;
   logic [IDX_W-1:0] fire_idx;
   assign req = ram_rd | ram_wr;
   assign out_of_range = |ram_addr[LINE_ADDR_W-1:LINE_BITS];
   assign last = idx_q == IDX_W'(LINE_HWORDS - 1);
   // fire is one cycle ahead of the pulse so the RAM read lines up with ram_get
   assign fire = (cnt_q == '0) && (state_q == LAT || (state_q == BURST && !last));
   assign fire_idx = (state_q == LAT) ? '0 : idx_q + 1'b1;
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         state_q <= IDLE;
         line_q <= '0;
         wr_q <= 1'b0;
         idx_q <= '0;
         cnt_q <= '0;
         get_q <= 1'b0;
         put_q <= 1'b0;
         busy_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         get_q <= fire & ~wr_q;
         put_q <= fire & wr_q;
         if (fire) begin
            idx_q <= fire_idx;
            cnt_q <= 8'(GAP);
         end else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
         case (state_q)
            IDLE: if (req) begin
               state_q <= LAT;
               line_q <= ram_addr[LINE_BITS-1:0];
               wr_q <= ram_wr;
               busy_q <= 1'b1;
               cnt_q <= 8'(START_LAT - 1);
               if (out_of_range) err_q <= 1'b1;
            end
            LAT: if (cnt_q == '0) state_q <= BURST;
            BURST: if (last) state_q <= wr_q ? FLUSH : HOLD;
            FLUSH: if (pv_q == '0) state_q <= HOLD;
            HOLD: if (!req) begin
               state_q <= IDLE;
               busy_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   // capture pipe: index of each put travels PUT_LAT cycles to meet its ram_din
   always_ff @(posedge cpu_clk) begin
      if (rst) pv_q <= '0;
      else for (int i = 0; i < PUT_LAT; i++) pv_q[i] <= (i == 0) ? put_q : pv_q[(i == 0) ? 0 : i-1];
   end
   always_ff @(posedge cpu_clk) begin
      for (int i = 0; i < PUT_LAT; i++) pi_q[i] <= (i == 0) ? idx_q : pi_q[(i == 0) ? 0 : i-1];
   end
   lmr_store #(.AW(IDX_W + LINE_BITS), .DW(HWORD_W)) u_store (
      .cpu_clk(cpu_clk),
      .rst(rst),
      .re(fire & ~wr_q),
      .ra({line_q, fire_idx}),
      .rdata(ram_dout),
      .we(pv_q[PUT_LAT-1]),
      .wa({line_q, pi_q[PUT_LAT-1]}),
      .wd(ram_din)
   );
   assign ram_get = get_q;
   assign ram_put = put_q;
   assign busy = busy_q;
   assign addr_err = err_q;
`ifdef LINE_MEM_RESP_STATS_EN
   logic [15:0] srd_q, swr_q, sal_q;
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         srd_q <= '0;
         swr_q <= '0;
         sal_q <= '0;
      end else if (state_q == IDLE && req) begin
         if (ram_wr) swr_q <= sat_inc(swr_q);
         else srd_q <= sat_inc(srd_q);
         if (out_of_range) sal_q <= sat_inc(sal_q);
      end
   end
   assign stat_rd = srd_q;
   assign stat_wr = swr_q;
   assign stat_alias = sal_q;
`else
   assign stat_rd = '0;
   assign stat_wr = '0;
   assign stat_alias = '0;
`endif
endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: randomized scoreboard bench; a line-array model predicts read data,
// a monitor pops expectations on ram_get and feeds ram_din PUT_LAT cycles after each ram_put.
module tb_line_mem_responder;
   localparam int ST = 4;
   localparam int PL = 2;
   logic cpu_clk = 1'b0, rst = 1'b1;
   logic [23:0] ram_addr = '0;
   logic ram_rd = 1'b0, ram_wr = 1'b0, g_rd = 1'b0;
   logic [15:0] ram_din = '0;
   logic [15:0] ram_dout, g_dout, stat_rd, stat_wr, stat_alias, g_srd, g_swr, g_sal;
   logic ram_get, ram_put, busy, addr_err, g_get, g_put, g_busy, g_err;
   int cyc = 0, checks = 0, failures = 0;
   logic [15:0] mem [64][128];
   bit kn [64][128];
   int exp_q [$];
   logic [15:0] wq [$];
   typedef struct {int c; logic [15:0] d;} din_t;
   din_t sched [$];

   line_mem_responder dut (
      .cpu_clk(cpu_clk), .rst(rst), .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr),
      .ram_din(ram_din), .ram_dout(ram_dout), .ram_get(ram_get), .ram_put(ram_put),
      .busy(busy), .addr_err(addr_err), .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_alias(stat_alias)
   );
   line_mem_responder #(.GAP(2)) dut_g (
      .cpu_clk(cpu_clk), .rst(rst), .ram_addr(ram_addr), .ram_rd(g_rd), .ram_wr(1'b0),
      .ram_din(ram_din), .ram_dout(g_dout), .ram_get(g_get), .ram_put(g_put),
      .busy(g_busy), .addr_err(g_err), .stat_rd(g_srd), .stat_wr(g_swr), .stat_alias(g_sal)
   );

   always #5 cpu_clk = ~cpu_clk;
   always @(posedge cpu_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   // monitor: scoreboard pop on ram_get, write-data driver on ram_put
   always @(negedge cpu_clk) begin
      int e;
      din_t s;
      if (ram_get) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_get: ram_get=1 with empty scoreboard at cycle %0d", cyc);
         end else begin
            e = exp_q.pop_front();
            if (e >= 0) chk("rd_data", int'(ram_dout), e);
         end
      end
      if (ram_put) begin
         if (wq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_put: ram_put=1 with no write data queued at cycle %0d", cyc);
         end else sched.push_back('{cyc + PL, wq.pop_front()});
      end
      while (sched.size() > 0 && sched[0].c < cyc) void'(sched.pop_front());
      if (sched.size() > 0 && sched[0].c == cyc) begin
         s = sched.pop_front();
         ram_din = s.d;
      end else ram_din = 16'($urandom);
   end

   task automatic burst(input logic [23:0] a, input bit rd, input bit wr, input int hold);
      int t0, first, n, prev, gets, bad, extra;
      @(negedge cpu_clk);
      ram_addr = a;
      ram_rd = rd;
      ram_wr = wr;
      t0 = cyc;
      @(negedge cpu_clk);
      chk("busy_rise", int'(busy), 1);
      n = 0; gets = 0; bad = 0; extra = 0; first = -1; prev = 0;
      for (int i = 0; i < 400 && n < 128; i++) begin
         if (ram_get | ram_put) begin
            if (n == 0) first = cyc;
            else if (cyc - prev != 1) bad++;
            prev = cyc;
            n++;
            gets += int'(ram_get);
         end
         if (n < 128) @(negedge cpu_clk);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge cpu_clk);
         if (ram_get | ram_put) extra++;
      end
      ram_rd = 1'b0;
      ram_wr = 1'b0;
      for (int i = 0; i < 50 && busy; i++) begin
         @(negedge cpu_clk);
         if (ram_get | ram_put) extra++;
      end
      chk("pulse_count", n, 128);
      chk("first_pulse_lat", first - t0, 1 + ST);
      chk("pulse_spacing_errs", bad, 0);
      chk("get_count", gets, wr ? 0 : 128);
      chk("extra_pulses", extra, 0);
      chk("busy_fall", int'(busy), 0);
   endtask

   task automatic wr_line(input logic [23:0] a, input bit both, input logic [15:0] d [128]);
      for (int k = 0; k < 128; k++) wq.push_back(d[k]);
      burst(a, both, 1'b1, 3);
      chk("wq_drained", wq.size(), 0);
      for (int k = 0; k < 128; k++) begin
         mem[a[5:0]][k] = d[k];
         kn[a[5:0]][k] = 1'b1;
      end
   endtask

   task automatic rd_line(input logic [23:0] a);
      for (int k = 0; k < 128; k++) exp_q.push_back(kn[a[5:0]][k] ? int'(mem[a[5:0]][k]) : -1);
      burst(a, 1'b1, 1'b0, 3);
      chk("exp_drained", exp_q.size(), 0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] d [128];
      int n, t0, first, prev, bad, extra, s0, op, l;
      repeat (3) @(negedge cpu_clk);
      chk("rst_get", int'(ram_get), 0);
      chk("rst_put", int'(ram_put), 0);
      chk("rst_dout", int'(ram_dout), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_addr_err", int'(addr_err), 0);
      chk("rst_stat_wr", int'(stat_wr), 0);
      rst = 1'b0;
      for (int k = 0; k < 128; k++) d[k] = 16'h0300 + 16'(k);
      wr_line(24'd3, 1'b0, d);
      rd_line(24'd3);
      for (int k = 0; k < 128; k++) d[k] = 16'hA000 + 16'(k);
      wr_line(24'd5, 1'b0, d);
      rd_line(24'd5);
      for (int it = 0; it < 8; it++) begin
         l = $urandom_range(0, 63);
         op = $urandom_range(0, 2);
         for (int k = 0; k < 128; k++) d[k] = 16'($urandom);
         if (op == 0) rd_line(24'(l));
         else wr_line(24'(l), op == 2, d);
      end
      rd_line(24'd3);
      // rd and wr together: write burst, write counter moves by exactly one
      s0 = int'(stat_wr);
      for (int k = 0; k < 128; k++) d[k] = 16'($urandom);
      wr_line(24'd12, 1'b1, d);
`ifdef LINE_MEM_RESP_STATS_EN
      chk("stat_wr_inc", int'(stat_wr), s0 + 1);
`else
      chk("stat_wr_tied", int'(stat_wr), s0);
`endif
      rd_line(24'd12);
      // alias: 0x40 maps onto line 0
      for (int k = 0; k < 128; k++) d[k] = 16'($urandom);
      wr_line(24'd0, 1'b0, d);
      chk("addr_err_clear", int'(addr_err), 0);
      rd_line(24'h000040);
      chk("addr_err_set", int'(addr_err), 1);
      for (int k = 0; k < 128; k++) d[k] = 16'h9000 + 16'(k);
      wr_line(24'd9, 1'b0, d);
      chk("addr_err_sticky", int'(addr_err), 1);
      // GAP=2 instance: 3-cycle spacing and no second burst while held
      @(negedge cpu_clk);
      ram_addr = 24'd7;
      g_rd = 1'b1;
      t0 = cyc;
      n = 0; bad = 0; extra = 0; first = -1; prev = 0;
      for (int i = 0; i < 1000 && n < 128; i++) begin
         @(negedge cpu_clk);
         if (g_get) begin
            if (n == 0) first = cyc;
            else if (cyc - prev != 3) bad++;
            prev = cyc;
            n++;
         end
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge cpu_clk);
         if (g_get | g_put) extra++;
      end
      g_rd = 1'b0;
      for (int i = 0; i < 20 && g_busy; i++) @(negedge cpu_clk);
      chk("gap_pulse_count", n, 128);
      chk("gap_first_lat", first - t0, 1 + ST);
      chk("gap_spacing_errs", bad, 0);
      chk("gap_no_rebust", extra, 0);
      chk("gap_busy_fall", int'(g_busy), 0);
      // reset in the cycle of write pulse 40 on line 9
      for (int k = 0; k < 128; k++) begin
         d[k] = 16'($urandom);
         wq.push_back(d[k]);
      end
      @(negedge cpu_clk);
      ram_addr = 24'd9;
      ram_wr = 1'b1;
      n = 0;
      for (int i = 0; i < 300 && n < 41; i++) begin
         @(negedge cpu_clk);
         if (ram_put) n++;
      end
      chk("rst_reached_pulse40", n, 41);
      rst = 1'b1;
      ram_wr = 1'b0;
      @(negedge cpu_clk);
      chk("midrst_put", int'(ram_put), 0);
      chk("midrst_get", int'(ram_get), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_addr_err", int'(addr_err), 0);
      rst = 1'b0;
      wq.delete();
      for (int k = 0; k < 39; k++) mem[9][k] = d[k];
      kn[9][39] = 1'b0;
      rd_line(24'd9);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
